// File: rtl/freq_bar_bank.sv
// Spectrum bar-height bank: software targets, per-frame attack/decay/peak-hold walk, registered read port.
// Optional build macro FREQ_BAR_CLAMP_EN clamps bar writes to MAX_HEIGHT.
module freq_bar_bank #(
  parameter int NUM_BARS         = 12,
  parameter int ADDR_W           = 4,
  parameter int HEIGHT_W         = 9,
  parameter int DECAY_STEP       = 4,
  parameter int PEAK_HOLD_FRAMES = 30,
  parameter int MAX_HEIGHT       = 240
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                chipselect,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [15:0]         writedata,
  input  logic                frame_tick,
  input  logic [ADDR_W-1:0]   rd_index,
  output logic [HEIGHT_W-1:0] rd_height,
  output logic [HEIGHT_W-1:0] rd_peak,
  output logic                busy,
  output logic                overrun
);

  localparam int HOLD_W = $clog2(PEAK_HOLD_FRAMES + 1);
  localparam logic [ADDR_W-1:0]   CTRL_ADDR = ADDR_W'(NUM_BARS);
  localparam logic [ADDR_W-1:0]   LAST_IDX  = ADDR_W'(NUM_BARS - 1);
  localparam logic [HOLD_W-1:0]   HOLD_INIT = HOLD_W'(PEAK_HOLD_FRAMES);
  localparam logic [HEIGHT_W-1:0] STEP      = HEIGHT_W'(DECAY_STEP);

  typedef enum logic {S_IDLE, S_WALK} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_idx;
  logic [1:0]          r_ctrl;
  logic [HEIGHT_W-1:0] r_target [NUM_BARS];
  logic [HEIGHT_W-1:0] r_disp   [NUM_BARS];
  logic [HEIGHT_W-1:0] r_peak   [NUM_BARS];
  logic [HOLD_W-1:0]   r_hold   [NUM_BARS];

  logic                w_bar_we, w_ctrl_we, w_walk;
  logic [HEIGHT_W-1:0] w_wdata;
  logic [HEIGHT_W-1:0] w_t, w_d, w_p, w_d_nxt, w_p_nxt;
  logic [HOLD_W-1:0]   w_h, w_h_nxt;
  logic                w_unused;

  assign w_bar_we  = chipselect && write && (address < CTRL_ADDR);
  assign w_ctrl_we = chipselect && write && (address == CTRL_ADDR);
  assign w_walk    = (r_state == S_WALK);
  assign w_unused  = ^{writedata, 16'(MAX_HEIGHT)};

`ifdef FREQ_BAR_CLAMP_EN
  // Compare on the full 16-bit word so large values cannot wrap below the ceiling.
  assign w_wdata = (writedata > 16'(MAX_HEIGHT)) ? HEIGHT_W'(MAX_HEIGHT) : writedata[HEIGHT_W-1:0];
`else
  assign w_wdata = writedata[HEIGHT_W-1:0];
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) r_idx <= '0;
      else                   r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (frame_tick) w_state_nxt = S_WALK;
      S_WALK:  if (r_idx == LAST_IDX) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (r_state == S_WALK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl  <= 2'b11;
      overrun <= 1'b0;
    end else begin
      if (w_ctrl_we) r_ctrl <= writedata[1:0];
      if (frame_tick && w_walk)              overrun <= 1'b1;
      else if (w_ctrl_we && writedata[15])   overrun <= 1'b0;
    end
  end

  // Bar under the walk pointer; target is the registered (pre-write) value.
  always_comb begin
    w_t = '0;
    w_d = '0;
    w_p = '0;
    w_h = '0;
    for (int i = 0; i < NUM_BARS; i++) begin
      if (r_idx == ADDR_W'(i)) begin
        w_t = r_target[i];
        w_d = r_disp[i];
        w_p = r_peak[i];
        w_h = r_hold[i];
      end
    end
  end

  always_comb begin
    w_d_nxt = w_t;
    if (r_ctrl[0] && (w_t < w_d))
      w_d_nxt = ((w_d - w_t) > STEP) ? (w_d - STEP) : w_t;
    w_p_nxt = w_d_nxt;
    w_h_nxt = '0;
    if (r_ctrl[1]) begin
      if (w_d_nxt >= w_p) begin
        w_p_nxt = w_d_nxt;
        w_h_nxt = HOLD_INIT;
      end else if (w_h != '0) begin
        w_p_nxt = w_p;
        w_h_nxt = w_h - 1'b1;
      end else begin
        w_p_nxt = ((w_p - 1'b1) > w_d_nxt) ? (w_p - 1'b1) : w_d_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BARS; i++) begin
        r_target[i] <= '0;
        r_disp[i]   <= '0;
        r_peak[i]   <= '0;
        r_hold[i]   <= '0;
      end
      rd_height <= '0;
      rd_peak   <= '0;
    end else begin
      for (int i = 0; i < NUM_BARS; i++) begin
        if (w_bar_we && (address == ADDR_W'(i))) r_target[i] <= w_wdata;
        if (w_walk && (r_idx == ADDR_W'(i))) begin
          r_disp[i] <= w_d_nxt;
          r_peak[i] <= w_p_nxt;
          r_hold[i] <= w_h_nxt;
        end
      end
      // Out-of-range read indices fall through to zero.
      rd_height <= '0;
      rd_peak   <= '0;
      for (int i = 0; i < NUM_BARS; i++) begin
        if (rd_index == ADDR_W'(i)) begin
          rd_height <= r_disp[i];
          rd_peak   <= r_peak[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_bar_bank.sv
// Directed bench for freq_bar_bank: reset, attack/decay, peak hold, walk timing, address edges, clamp.
module tb_freq_bar_bank;
  localparam int NB = 12;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       chipselect, write, frame_tick;
  logic [3:0] address, rd_index;
  logic [15:0] writedata;
  logic [8:0] rd_height, rd_peak;
  logic       busy, overrun;

  int checks = 0;
  int errors = 0;
  int cyc;

  freq_bar_bank dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata), .frame_tick(frame_tick),
    .rd_index(rd_index), .rd_height(rd_height), .rd_peak(rd_peak),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] idx, input int eh, input int ep);
    rd_index = idx;
    @(negedge clk);
    chk({tag, "_h"}, 32'(rd_height), 32'(eh));
    chk({tag, "_p"}, 32'(rd_peak), 32'(ep));
  endtask

  // Pulse frame_tick and return the number of cycles busy stays high.
  task automatic tick(output int n);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; frame_tick = 1'b0;
    address = '0; writedata = '0; rd_index = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rd("rst_bar0", 4'd0, 0, 0);
    rd("rst_bar11", 4'd11, 0, 0);

    // Attack, walk length
    wr(4'd3, 16'd100);
    wr(4'd11, 16'd77);
    tick(cyc);
    chk("walk_len", 32'(cyc), 12);
    rd("attack_bar3", 4'd3, 100, 100);
    rd("attack_bar11", 4'd11, 77, 77);

    // Decay to target with peak hold (30 ticks) then peak droop
    wr(4'd3, 16'd10);
    for (int k = 1; k <= 33; k++) begin
      int eh, ep;
      eh = (100 - 4*k > 10) ? 100 - 4*k : 10;
      ep = (k <= 30) ? 100 : 100 - (k - 30);
      tick(cyc);
      rd($sformatf("decay_k%0d", k), 4'd3, eh, ep);
    end

    // CTRL=0: no decay, peak follows disp
    wr(4'd12, 16'h0000);
    wr(4'd3, 16'd100);
    tick(cyc);
    rd("nodecay_up", 4'd3, 100, 100);
    wr(4'd3, 16'd10);
    tick(cyc);
    rd("nodecay_down", 4'd3, 10, 10);
    wr(4'd12, 16'h0003);

    // Second tick during walk: overrun, walk not restarted
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    cyc = 0;
    while (busy && cyc < 50) begin
      cyc++;
      frame_tick = (cyc == 5);
      @(negedge clk);
    end
    frame_tick = 1'b0;
    chk("ovr_walk_len", 32'(cyc), 12);
    chk("ovr_set", 32'(overrun), 1);

    // Address beyond CTRL is ignored
    wr(4'd13, 16'h8000);
    chk("addr13_ignored", 32'(overrun), 1);
    wr(4'd12, 16'h8003);
    chk("ovr_clear", 32'(overrun), 0);
    rd("rd_idx12", 4'd12, 0, 0);
    rd("rd_idx15", 4'd15, 0, 0);

    // Writes during walk: passed (bar0), same-cycle (bar7), not yet reached (bar9)
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    cyc = 0;
    while (busy && cyc < 50) begin
      cyc++;
      chipselect = 1'b0; write = 1'b0;
      if (cyc == 6) begin chipselect = 1'b1; write = 1'b1; address = 4'd0; writedata = 16'd50; end
      if (cyc == 7) begin chipselect = 1'b1; write = 1'b1; address = 4'd9; writedata = 16'd30; end
      if (cyc == 8) begin chipselect = 1'b1; write = 1'b1; address = 4'd7; writedata = 16'd60; end
      @(negedge clk);
    end
    chipselect = 1'b0; write = 1'b0;
    rd("midwalk_bar0_now", 4'd0, 0, 0);
    rd("midwalk_bar7_now", 4'd7, 0, 0);
    rd("midwalk_bar9_now", 4'd9, 30, 30);
    tick(cyc);
    rd("midwalk_bar0_next", 4'd0, 50, 50);
    rd("midwalk_bar7_next", 4'd7, 60, 60);

    // Clamp / truncate
    wr(4'd0, 16'h0190);
    wr(4'd1, 16'h0300);
    tick(cyc);
`ifdef FREQ_BAR_CLAMP_EN
    rd("clamp_400", 4'd0, 240, 240);
    rd("clamp_768", 4'd1, 240, 240);
`else
    rd("trunc_400", 4'd0, 400, 400);
    rd("trunc_768", 4'd1, 256, 256);
`endif

    // Reset mid-walk aborts immediately
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rd_h", 32'(rd_height), 0);
    @(negedge clk);
    reset_n = 1'b1;
    rd("midrst_bar0", 4'd0, 0, 0);
    tick(cyc);
    rd("midrst_target_cleared", 4'd0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
